// File: rtl/regfile_scoreboard.sv
// 2-read/1-write register file with pending-write scoreboard and a sequential clear sweep.
// Optional write-through bypass on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clear_req,
    output logic              clear_busy
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, SWEEP} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              clear_busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pending_q, pending_d;
    logic              idle, wr_ok, rsv_ok;

    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [1:0]             busy;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    assign idle   = (state_q == IDLE);
    // rst_n gating keeps a bypassed write from leaking onto rd_data during reset
    assign wr_ok  = wr_en && idle && rst_n && !is_zero(wr_addr);
    assign rsv_ok = rsv_en && idle && !is_zero(rsv_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            clear_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (clear_req) begin
                    state_q      <= SWEEP;
                    ptr_q        <= '0;
                    clear_busy_q <= 1'b1;
                end
                SWEEP: begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                    if (&ptr_q) begin
                        state_q      <= IDLE;
                        clear_busy_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reservation is applied after the write so a same-cycle younger reservation wins.
    always_comb begin
        mem_d     = mem_q;
        pending_d = pending_q;
        if (!idle) begin
            mem_d[ptr_q] = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_addr]     = wr_data;
                pending_d[wr_addr] = 1'b0;
            end
            if (rsv_ok) pending_d[rsv_addr] = 1'b1;
            if (clear_req) pending_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            pending_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            pending_q <= pending_d;
        end
    end

    assign rd_addr[0] = rd_addr_a;
    assign rd_addr[1] = rd_addr_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = mem_q[rd_addr[p]];
            busy[p]    = pending_q[rd_addr[p]] | !idle;
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == rd_addr[p])) begin
                rd_data[p] = wr_data;
                busy[p]    = 1'b0;
            end
`endif
            if (is_zero(rd_addr[p])) begin
                rd_data[p] = '0;
                busy[p]    = 1'b0;
            end
        end
    end

    assign rd_data_a  = rd_data[0];
    assign rd_data_b  = rd_data[1];
    assign busy_a     = busy[0];
    assign busy_b     = busy[1];
    assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: a behavioural model predicts each cycle's read-port outputs,
// which are queued when inputs are driven and compared when sampled on the falling edge.
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
    logic [DW-1:0] rd_data_a, rd_data_b, wr_data;
    logic          busy_a, busy_b, wr_en, rsv_en, clear_req, clear_busy;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .clear_req(clear_req), .clear_busy(clear_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] da, db;
        logic          ba, bb, cb;
    } exp_t;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_pend [DEPTH];
    logic          m_sweep;
    int            m_ptr;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_sweep = 1'b0;
        m_ptr   = 0;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
        end else if (m_sweep) begin
            m_mem[m_ptr] = '0;
            if (m_ptr == DEPTH-1) m_sweep = 1'b0;
            m_ptr++;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
            if (clear_req) begin
                for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
                m_sweep = 1'b1;
                m_ptr   = 0;
            end
        end
    endtask

    function automatic void exp_rd(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic b);
        if (!rst_n || a == 0) begin
            d = '0;
            b = 1'b0;
        end else if (m_sweep) begin
            d = m_mem[a];
            b = 1'b1;
        end else begin
            d = m_mem[a];
            b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && wr_addr == a) begin
                d = wr_data;
                b = 1'b0;
            end
`endif
        end
    endfunction

    // One clock: predict, sample mid-cycle, then advance model at the rising edge.
    task automatic cycle();
        exp_t e;
        exp_rd(rd_addr_a, e.da, e.ba);
        exp_rd(rd_addr_b, e.db, e.bb);
        e.cb = m_sweep && rst_n;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("rd_data_a", rd_data_a, e.da);
        chk("rd_data_b", rd_data_b, e.db);
        chk("busy_a", busy_a, e.ba);
        chk("busy_b", busy_b, e.bb);
        chk("clear_busy", clear_busy, e.cb);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_in();
        wr_en = 1'b0; rsv_en = 1'b0; clear_req = 1'b0;
        wr_addr = '0; rsv_addr = '0; wr_data = '0;
    endtask

    task automatic fill_all();
        for (int i = 1; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = $urandom; rd_addr_a = AW'(i);
            cycle();
        end
        idle_in();
    endtask

    task automatic read_all();
        for (int i = 1; i < DEPTH; i++) begin
            rd_addr_a = AW'(i); rd_addr_b = AW'(DEPTH - i);
            cycle();
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        idle_in();
        model_reset();
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();

        // asynchronous reset with live data at entry 7
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hDEADBEEF; rd_addr_a = 7;
        cycle();
        idle_in();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rd_a", rd_data_a, 32'h0);
        chk("async_rst_busy_a", busy_a, 1'b0);
        chk("async_rst_clear_busy", clear_busy, 1'b0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();

        // hard-wired zero entry
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678;
        rsv_en = 1'b1; rsv_addr = 0; rd_addr_a = 0; rd_addr_b = 0;
        cycle();
        idle_in();
        repeat (3) cycle();

        // reserve then write entry 9
        rsv_en = 1'b1; rsv_addr = 9; rd_addr_a = 9; rd_addr_b = 9;
        cycle();
        rsv_en = 1'b0;
        cycle();
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'hA5A5A5A5;
        cycle();
        idle_in();
        cycle();

        // same-cycle reserve and write to entry 4: reservation wins
        rsv_en = 1'b1; rsv_addr = 4; wr_en = 1'b1; wr_addr = 4; wr_data = 32'h55;
        rd_addr_a = 4; rd_addr_b = 4;
        cycle();
        idle_in();
        repeat (2) cycle();
        chk("rsv_wins_busy_a", busy_a, 1'b1);
        wr_en = 1'b1; wr_addr = 4; wr_data = 32'h66;
        cycle();
        idle_in();
        cycle();

        // random traffic
        repeat (300) begin
            wr_en = 1'($urandom); wr_addr = AW'($urandom); wr_data = $urandom;
            rsv_en = 1'($urandom); rsv_addr = AW'($urandom);
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rsv_addr : AW'($urandom);
            cycle();
        end
        idle_in();

        // full clear sweep with writes and reservations attempted during it
        fill_all();
        rsv_en = 1'b1; rsv_addr = 3;
        cycle();
        rsv_en = 1'b0; clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_en = 1'b1; wr_addr = AW'($urandom_range(1, 31)); wr_data = $urandom;
            rsv_en = 1'($urandom); rsv_addr = AW'($urandom_range(1, 31));
            clear_req = 1'($urandom);
            rd_addr_a = AW'($urandom_range(1, 31)); rd_addr_b = AW'($urandom_range(1, 31));
            if (clear_busy && busy_a && busy_b) cnt++;
            cycle();
        end
        idle_in();
        chk("sweep_window", cnt, DEPTH);
        chk("sweep_done", clear_busy, 1'b0);
        read_all();

        // reset aborts a sweep; a fresh sweep then runs its full length from entry 0
        fill_all();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        repeat (10) cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_clear_busy", clear_busy, 1'b0);
        chk("abort_busy_a", busy_a, 1'b0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();
        fill_all();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < DEPTH + 8; k++) begin
            if (clear_busy) cnt++;
            cycle();
        end
        chk("resweep_len", cnt, DEPTH);
        read_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised 2-read/1-write register file for the pipelined MIPS datapath.
- Adds asynchronous reset, an optional hard-wired zero register and a per-register pending-write scoreboard for hazard detection.
- Adds a sequential clear engine that zeroes the file one entry per cycle.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (derived, not overridable).
- ZERO_REG, 1, 1 = entry 0 is hard-wired zero: never written, never reserved, always reads 0. 0 = entry 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  read port A data (combinational).
- rd_data_b  out  DATA_W  read port B data (combinational).
- busy_a  out  1  entry at rd_addr_a has a pending write; data not valid.
- busy_b  out  1  same for rd_addr_b.
- wr_en  in  1  writeback write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rsv_en  in  1  reserve entry rsv_addr (instruction issued with that destination).
- rsv_addr  in  ADDR_W  reservation address.
- clear_req  in  1  start clear sweep (level, sampled in IDLE only).
- clear_busy  out  1  clear sweep in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All entries become 0 and all pending bits become 0.
  - FSM goes to IDLE and sweep pointer goes to 0.
  - Outputs while in reset: clear_busy=0, busy_a=busy_b=0, rd_data = 0.
- Zero entry (ZERO_REG=1, address 0):
  - Writes and reservations are ignored.
  - rd_data returns 0 and busy returns 0, regardless of bypass.
- Write: at posedge, if wr_en, the FSM is in IDLE, and the address is legal, entry[wr_addr] <= wr_data. New value is visible on reads from the next cycle.
- Read: combinational, zero latency. Bypass rules are under Optional Feature.
- Scoreboard, one pending bit per entry:
  - rsv_en sets pending[rsv_addr].
  - wr_en clears pending[wr_addr].
  - rsv_en and wr_en to the same address in the same cycle: the set wins, because the reservation belongs to a younger instruction. The data write still happens.
  - Reserving an already-pending entry leaves it pending (no count).
  - busy_x = pending[rd_addr_x], subject to the bypass rule.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when clear_req=1. On entry, all pending bits are cleared and ptr is set to 0.
  - SWEEP: each cycle entry[ptr] <= 0 and ptr increments. When ptr == DEPTH-1 the final entry is zeroed and the FSM returns to IDLE.
  - Sweep duration is exactly DEPTH cycles; clear_busy is high for all of them.
  - During SWEEP, wr_en, rsv_en and clear_req are ignored. busy_a and busy_b are forced to 1, and rd_data shows current array contents.
  - rst_n low during SWEEP aborts immediately to the reset state.
- Widths: addresses are used unsigned and ptr wraps naturally at DEPTH, so no out-of-range entries exist.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through bypass): when wr_en is valid (IDLE, legal address) and wr_addr == rd_addr_x:
  - rd_data_x = wr_data in the same cycle.
  - busy_x = 0, even if pending is set.
  - This also applies when rsv_en re-sets that bit in the same cycle.
- Undefined: rd_data_x returns the stored value and busy_x follows pending[rd_addr_x] unmodified. The new data and busy=0 appear one cycle after the write.

Test Plan:
- Reset then read: rst_n=0 mid-run with file holding 0xDEADBEEF at entry 7 -> rd_data_a=0 immediately (asynchronously), busy_a=0, clear_busy=0.
- Zero register: ZERO_REG=1, write 0x12345678 to addr 0 and rsv_en to addr 0 -> rd_data_a(addr 0)=0, busy_a=0 on all following cycles.
- Scoreboard sequence:
  - rsv addr 9 -> busy_a(9)=1 from the next cycle.
  - Write 0xA5A5A5A5 to 9 -> with REGFILE_BYPASS_EN: same-cycle rd_data_a=0xA5A5A5A5 and busy_a=0. Without it: same-cycle old data and busy_a=1, then next cycle new data and busy_a=0.
- Simultaneous reserve and write to entry 4 with data 0x55 -> entry 4 reads 0x55 afterwards and busy stays 1 until the next write to 4.
- Clear sweep, ADDR_W=5:
  - Fill entries 1..31, pend entry 3, pulse clear_req -> clear_busy high for 32 cycles and busy_a=busy_b=1 throughout.
  - wr_en in that window is ignored.
  - Afterwards all entries read 0 and no pending bits are set.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 10 -> clear_busy=0 immediately, FSM IDLE after release; a new clear_req starts a full DEPTH-cycle sweep from ptr 0.
